// File: rtl/pll_reset_pkg.sv
// +----------------------------------------------------------------------+
// | pll_reset_pkg : shared types for the PLL lock supervisor              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package pll_reset_pkg;

  typedef enum logic [1:0] {
    PLLRST    = 2'd0,
    WAIT_LOCK = 2'd1,
    REL1      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int RELOCK_W = 8;

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == {RELOCK_W{1'b1}}) ? v : v + RELOCK_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_seq_if.sv
// +----------------------------------------------------------------------+
// | pll_reset_seq_if : lock input, reset outputs and status of supervisor |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface pll_reset_seq_if;
  import pll_reset_pkg::*;

  logic                pll_locked;
  logic                clr_lost;
  logic                pll_rst;
  logic                rst_n;
  logic                rst_late_n;
  logic                ready;
  logic                lock_lost;
  logic [RELOCK_W-1:0] relock_count;

  modport master (
    output pll_locked, clr_lost,
    input  pll_rst, rst_n, rst_late_n, ready, lock_lost, relock_count
  );

  modport slave (
    input  pll_locked, clr_lost,
    output pll_rst, rst_n, rst_late_n, ready, lock_lost, relock_count
  );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------+
// | sync_2ff : 1-bit two-flop synchronizer, async active-low reset to 0   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], d};
    end
  end

  assign q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// +----------------------------------------------------------------------+
// | pll_reset_seq : PLL lock supervisor and two-stage reset sequencer     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int PLLRST_CYCLES  = 16,
  parameter int STAGE_GAP      = 16,
  parameter int CNT_W          = 21
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  pll_reset_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_pllrst_last  = CNT_W'(PLLRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

  logic                w_lock_s;
  state_t              r_state;
  logic [CNT_W-1:0]    r_phase_cnt;
  logic [CNT_W-1:0]    r_stable_cnt;
  logic [CNT_W-1:0]    r_timeout_cnt;
  logic                r_pll_rst;
  logic                r_rst_n;
  logic                r_rst_late_n;
  logic                r_ready;
  logic                r_lock_lost;
  logic [RELOCK_W-1:0] r_relock_count;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (bus.pll_locked),
    .q     (w_lock_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= PLLRST;
      r_phase_cnt    <= '0;
      r_stable_cnt   <= '0;
      r_timeout_cnt  <= '0;
      r_pll_rst      <= 1'b1;
      r_rst_n        <= 1'b0;
      r_rst_late_n   <= 1'b0;
      r_ready        <= 1'b0;
      r_lock_lost    <= 1'b0;
      r_relock_count <= '0;
    end else begin
      // A loss below overrides this clear on the same cycle.
      if (bus.clr_lost) begin
        r_lock_lost <= 1'b0;
      end

      case (r_state)
        PLLRST: begin
          if (r_phase_cnt == c_pllrst_last) begin
            r_state       <= WAIT_LOCK;
            r_phase_cnt   <= '0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_pll_rst     <= 1'b0;
          end else begin
            r_phase_cnt <= r_phase_cnt + c_one;
          end
        end

        WAIT_LOCK: begin
          r_timeout_cnt <= r_timeout_cnt + c_one;
          r_stable_cnt  <= w_lock_s ? r_stable_cnt + c_one : '0;
          // Stable lock takes priority over a coincident timeout.
          if (w_lock_s && (r_stable_cnt == c_stable_last)) begin
            r_state     <= REL1;
            r_phase_cnt <= '0;
            r_rst_n     <= 1'b1;
          end else if (r_timeout_cnt == c_timeout_last) begin
            r_state     <= PLLRST;
            r_phase_cnt <= '0;
            r_pll_rst   <= 1'b1;
          end
        end

        REL1, RUN: begin
          if (!w_lock_s) begin
            r_state        <= PLLRST;
            r_phase_cnt    <= '0;
            r_pll_rst      <= 1'b1;
            r_rst_n        <= 1'b0;
            r_rst_late_n   <= 1'b0;
            r_ready        <= 1'b0;
            r_lock_lost    <= 1'b1;
            r_relock_count <= sat_inc(r_relock_count);
          end else if (r_state == REL1) begin
            if (r_phase_cnt == c_gap_last) begin
              r_state      <= RUN;
              r_rst_late_n <= 1'b1;
              r_ready      <= 1'b1;
            end else begin
              r_phase_cnt <= r_phase_cnt + c_one;
            end
          end
        end

        default: begin
          r_state <= PLLRST;
        end
      endcase
    end
  end

  assign bus.pll_rst      = r_pll_rst;
  assign bus.rst_n        = r_rst_n;
  assign bus.rst_late_n   = r_rst_late_n;
  assign bus.ready        = r_ready;
  assign bus.lock_lost    = r_lock_lost;
  assign bus.relock_count = r_relock_count;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// +----------------------------------------------------------------------+
// | tb_pll_reset_seq : directed self-checking bench for pll_reset_seq     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pll_reset_seq;

  localparam int STABLE_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int PLLRST_CYCLES  = 4;
  localparam int STAGE_GAP      = 3;
  localparam int CNT_W          = 8;

  logic clk = 1'b0;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pll_reset_seq_if bus ();

  pll_reset_seq #(
    .STABLE_CYCLES  (STABLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .PLLRST_CYCLES  (PLLRST_CYCLES),
    .STAGE_GAP      (STAGE_GAP),
    .CNT_W          (CNT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic wait_rst_n(input int budget);
    int k = 0;
    while (bus.rst_n !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (bus.rst_n !== 1'b1) check_eq("wait_rst_n_timeout", 32'(bus.rst_n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic bad;
    resetn         = 1'b1;
    bus.pll_locked = 1'b0;
    bus.clr_lost   = 1'b0;

    // Reset values, checked asynchronously before any clock edge matters
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_pll_rst",    32'(bus.pll_rst),      32'd1);
    check_eq("rst_rst_n",      32'(bus.rst_n),        32'd0);
    check_eq("rst_rst_late_n", 32'(bus.rst_late_n),   32'd0);
    check_eq("rst_ready",      32'(bus.ready),        32'd0);
    check_eq("rst_lock_lost",  32'(bus.lock_lost),    32'd0);
    check_eq("rst_relock",     32'(bus.relock_count), 32'd0);

    // No lock: 4-cycle PLL reset, 64-cycle wait, then retry
    repeat (2) tick();
    resetn = 1'b1;
    repeat (3) tick();
    check_eq("nolock_pllrst_e3", 32'(bus.pll_rst), 32'd1);
    tick();
    check_eq("nolock_pllrst_e4", 32'(bus.pll_rst), 32'd0);
    bad = 1'b0;
    repeat (63) begin
      tick();
      if (bus.rst_n || bus.rst_late_n || bus.ready || bus.pll_rst) bad = 1'b1;
    end
    check_eq("nolock_quiet_wait", 32'(bad), 32'd0);
    tick();
    check_eq("nolock_retry_pllrst", 32'(bus.pll_rst),   32'd1);
    check_eq("nolock_lock_lost",    32'(bus.lock_lost), 32'd0);

    // Lock rising just after entering WAIT_LOCK
    apply_reset();
    repeat (4) tick();
    bus.pll_locked = 1'b1;
    repeat (9) tick();
    check_eq("rel_rst_n_e9", 32'(bus.rst_n), 32'd0);
    tick();
    check_eq("rel_rst_n_e10", 32'(bus.rst_n),      32'd1);
    check_eq("rel_late_e10",  32'(bus.rst_late_n), 32'd0);
    repeat (2) tick();
    check_eq("rel_late_e12", 32'(bus.rst_late_n), 32'd0);
    tick();
    check_eq("rel_late_e13",   32'(bus.rst_late_n), 32'd1);
    check_eq("rel_ready_e13",  32'(bus.ready),      32'd1);
    check_eq("rel_pllrst_e13", 32'(bus.pll_rst),    32'd0);

    // Lock loss in RUN, then the full sequence again
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    check_eq("loss_rst_n_e2", 32'(bus.rst_n), 32'd1);
    check_eq("loss_ready_e2", 32'(bus.ready), 32'd1);
    tick();
    check_eq("loss_rst_n_e3",   32'(bus.rst_n),        32'd0);
    check_eq("loss_late_e3",    32'(bus.rst_late_n),   32'd0);
    check_eq("loss_ready_e3",   32'(bus.ready),        32'd0);
    check_eq("loss_pllrst_e3",  32'(bus.pll_rst),      32'd1);
    check_eq("loss_lost_e3",    32'(bus.lock_lost),    32'd1);
    check_eq("loss_relock_e3",  32'(bus.relock_count), 32'd1);
    bus.pll_locked = 1'b1;
    repeat (3) tick();
    check_eq("relock_pllrst_e6", 32'(bus.pll_rst), 32'd1);
    tick();
    check_eq("relock_pllrst_e7", 32'(bus.pll_rst), 32'd0);
    repeat (7) tick();
    check_eq("relock_rst_n_e14", 32'(bus.rst_n), 32'd0);
    tick();
    check_eq("relock_rst_n_e15", 32'(bus.rst_n), 32'd1);
    repeat (3) tick();
    check_eq("relock_ready_e18", 32'(bus.ready),      32'd1);
    check_eq("relock_late_e18",  32'(bus.rst_late_n), 32'd1);

    // One-cycle lock glitch in WAIT_LOCK restarts the stable count
    apply_reset();
    repeat (4) tick();
    bus.pll_locked = 1'b1;
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    repeat (4) tick();
    check_eq("glitch_rst_n_e10", 32'(bus.rst_n), 32'd0);
    repeat (5) tick();
    check_eq("glitch_rst_n_e15", 32'(bus.rst_n), 32'd0);
    tick();
    check_eq("glitch_rst_n_e16", 32'(bus.rst_n), 32'd1);

    // 300 losses: saturation, and set-wins over clr_lost on the last one
    apply_reset();
    bus.pll_locked = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      bus.pll_locked = 1'b1;
      wait_rst_n(100);
      bus.pll_locked = 1'b0;
      repeat (2) tick();
      if (i == 300) bus.clr_lost = 1'b1;
      tick();
      bus.clr_lost = 1'b0;
      if (i == 1)   check_eq("sat_relock_1",   32'(bus.relock_count), 32'd1);
      if (i == 254) check_eq("sat_relock_254", 32'(bus.relock_count), 32'd254);
      if (i == 255) check_eq("sat_relock_255", 32'(bus.relock_count), 32'd255);
      if (i == 256) check_eq("sat_relock_256", 32'(bus.relock_count), 32'd255);
      if (i == 300) begin
        check_eq("sat_relock_300",    32'(bus.relock_count), 32'd255);
        check_eq("clr_vs_loss_lost",  32'(bus.lock_lost),    32'd1);
      end
    end
    repeat (2) tick();
    bus.clr_lost = 1'b1;
    tick();
    bus.clr_lost = 1'b0;
    check_eq("clr_alone_lost",   32'(bus.lock_lost),    32'd0);
    check_eq("clr_alone_relock", 32'(bus.relock_count), 32'd255);

    // Asynchronous reset pulse while in REL1
    bus.pll_locked = 1'b1;
    wait_rst_n(100);
    check_eq("areset_pre_relock", 32'(bus.relock_count), 32'd255);
    #3 resetn = 1'b0;
    #2;
    check_eq("areset_pll_rst", 32'(bus.pll_rst),      32'd1);
    check_eq("areset_rst_n",   32'(bus.rst_n),        32'd0);
    check_eq("areset_late",    32'(bus.rst_late_n),   32'd0);
    check_eq("areset_ready",   32'(bus.ready),        32'd0);
    check_eq("areset_relock",  32'(bus.relock_count), 32'd0);
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check_eq("areset_seq_pllrst_e3", 32'(bus.pll_rst), 32'd1);
    tick();
    check_eq("areset_seq_pllrst_e4", 32'(bus.pll_rst), 32'd0);
    repeat (7) tick();
    check_eq("areset_seq_rst_n_e11", 32'(bus.rst_n), 32'd0);
    tick();
    check_eq("areset_seq_rst_n_e12", 32'(bus.rst_n), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
